cache_mem_arbiter: RTL and testbench

//  Round-robin arbiter sharing one memory port among NUM_REQ cache controllers (e.g. I$ and D$).

---
 rtl/cache_mem_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// Round-robin arbiter that shares one memory port among NUM_REQ cache
// controllers. A granted transaction is held on the memory port until
// mem_ready arrives or the per-transaction timeout expires. Completion is
// reported with a one-cycle req_ready pulse, plus req_err on a timeout.
module cache_mem_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_read,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            req_err,
  output logic [DATA_WIDTH-1:0]         req_rdata,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_data_out,
  output logic                          mem_read,
  output logic                          mem_write,
  input  logic [DATA_WIDTH-1:0]         mem_data_in,
  input  logic                          mem_ready,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int IW = $clog2(NUM_REQ);
  // A zero-width counter is illegal, so a disabled timeout keeps one dummy bit.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  logic [IW-1:0]           rr_ptr_r, rr_ptr_s;
  logic [CW-1:0]           cnt_r, cnt_s;
  logic                    is_write_r, is_write_s;

  logic [NUM_REQ-1:0]      active_s;
  logic                    pick_valid_s;
  logic [IW-1:0]           pick_idx_s;
  logic [IW-1:0]           cand_s;

  logic [NUM_REQ-1:0]      req_ready_s, req_err_s;
  logic [DATA_WIDTH-1:0]   req_rdata_s;
  logic [ADDR_WIDTH-1:0]   mem_addr_s;
  logic [DATA_WIDTH-1:0]   mem_data_out_s;
  logic                    mem_read_s, mem_write_s, busy_s;
  logic [IW-1:0]           grant_id_s;

  assign active_s = req_read | req_write;

  // Round-robin pick: scan from farthest to nearest so the first active index after rr_ptr wins.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_idx_s   = '0;
    cand_s       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_s = IW'((int'(rr_ptr_r) + k) % NUM_REQ);
      if (active_s[cand_s]) begin
        pick_valid_s = 1'b1;
        pick_idx_s   = cand_s;
      end else begin
        pick_valid_s = pick_valid_s;
      end
    end
  end

  // Next-state and next-output logic; every register holds unless a transition changes it.
  always_comb begin
    state_s        = state_r;
    rr_ptr_s       = rr_ptr_r;
    cnt_s          = cnt_r;
    is_write_s     = is_write_r;
    grant_id_s     = grant_id;
    mem_addr_s     = mem_addr;
    mem_data_out_s = mem_data_out;
    mem_read_s     = mem_read;
    mem_write_s    = mem_write;
    req_rdata_s    = req_rdata;
    req_ready_s    = '0;
    req_err_s      = '0;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          grant_id_s = pick_idx_s;
          mem_addr_s = req_addr[int'(pick_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
          cnt_s      = '0;
          state_s    = BUSY;
          // Both strobes high on one requester is treated as a write.
          if (req_write[pick_idx_s]) begin
            is_write_s     = 1'b1;
            mem_data_out_s = req_wdata[int'(pick_idx_s)*DATA_WIDTH +: DATA_WIDTH];
            mem_write_s    = 1'b1;
            mem_read_s     = 1'b0;
          end else begin
            is_write_s  = 1'b0;
            mem_write_s = 1'b0;
            mem_read_s  = 1'b1;
          end
        end else begin
          mem_read_s  = 1'b0;
          mem_write_s = 1'b0;
        end
      end
      BUSY: begin
        // mem_ready on the timeout cycle wins: it is a normal completion.
        if (mem_ready) begin
          mem_read_s             = 1'b0;
          mem_write_s            = 1'b0;
          req_ready_s[grant_id]  = 1'b1;
          rr_ptr_s               = grant_id;
          state_s                = DONE;
          if (is_write_r) begin
            req_rdata_s = req_rdata;
          end else begin
            req_rdata_s = mem_data_in;
          end
        end else if (TO_EN && (cnt_r == CNT_LAST)) begin
          mem_read_s             = 1'b0;
          mem_write_s            = 1'b0;
          req_ready_s[grant_id]  = 1'b1;
          req_err_s[grant_id]    = 1'b1;
          req_rdata_s            = '0;
          rr_ptr_s               = grant_id;
          state_s                = DONE;
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      DONE: begin
        // Requests are not sampled here so a finished requester can drop its strobe.
        state_s = IDLE;
      end
      default: begin
        state_s     = IDLE;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered datapath and outputs; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r     <= IW'(NUM_REQ - 1);
      cnt_r        <= '0;
      is_write_r   <= 1'b0;
      grant_id     <= '0;
      mem_addr     <= '0;
      mem_data_out <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      req_rdata    <= '0;
      req_ready    <= '0;
      req_err      <= '0;
      busy         <= 1'b0;
    end else begin
      rr_ptr_r     <= rr_ptr_s;
      cnt_r        <= cnt_s;
      is_write_r   <= is_write_s;
      grant_id     <= grant_id_s;
      mem_addr     <= mem_addr_s;
      mem_data_out <= mem_data_out_s;
      mem_read     <= mem_read_s;
      mem_write    <= mem_write_s;
      req_rdata    <= req_rdata_s;
      req_ready    <= req_ready_s;
      req_err      <= req_err_s;
      busy         <= busy_s;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Testbench for cache_mem_arbiter: directed scenarios followed by random
// requester/memory traffic, all checked against a transaction-level model.
module tb_cache_mem_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int TO = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_read, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready, req_err;
  logic [DW-1:0]   req_rdata;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data_out, mem_data_in;
  logic            mem_read, mem_write, mem_ready;
  logic [IW-1:0]   grant_id;
  logic            busy;

  cache_mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .req_err(req_err), .req_rdata(req_rdata),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_read(mem_read), .mem_write(mem_write),
    .mem_data_in(mem_data_in), .mem_ready(mem_ready), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit            m_inflight, m_ack, m_wr;
  int            m_waited, m_grant, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [N-1:0]  m_ready, m_err;

  task automatic model_reset();
    m_inflight = 0; m_ack = 0; m_wr = 0; m_waited = 0;
    m_grant = 0; m_last = N - 1;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_ready = '0; m_err = '0;
  endtask

  // Advances the model across one clock edge using the inputs currently driven.
  task automatic model_step();
    bit found;
    int j;
    found = 0;
    m_ready = '0;
    m_err   = '0;
    if (m_ack) begin
      m_ack = 0;
    end else if (!m_inflight) begin
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (!found && (req_read[j] || req_write[j])) begin
          found = 1;
          m_grant = j;
        end
      end
      if (found) begin
        m_inflight = 1;
        m_wr       = req_write[m_grant];
        m_addr     = req_addr[m_grant*AW +: AW];
        if (m_wr) m_wdata = req_wdata[m_grant*DW +: DW];
        m_waited   = 0;
      end
    end else begin
      m_waited++;
      if (mem_ready === 1'b1 || m_waited == TO) begin
        if (mem_ready === 1'b1) begin
          if (!m_wr) m_rdata = mem_data_in;
        end else begin
          m_rdata = '0;
          m_err[m_grant] = 1'b1;
        end
        m_ready[m_grant] = 1'b1;
        m_inflight = 0;
        m_ack      = 1;
        m_last     = m_grant;
      end
    end
  endtask

  task automatic compare();
    check("mem_read",  64'(mem_read),  64'(m_inflight && !m_wr));
    check("mem_write", 64'(mem_write), 64'(m_inflight && m_wr));
    if (m_inflight) check("mem_addr", 64'(mem_addr), 64'(m_addr));
    if (m_inflight && m_wr) check("mem_data_out", 64'(mem_data_out), 64'(m_wdata));
    check("req_ready", 64'(req_ready), 64'(m_ready));
    check("req_err",   64'(req_err),   64'(m_err));
    check("req_rdata", 64'(req_rdata), 64'(m_rdata));
    check("grant_id",  64'(grant_id),  64'(m_grant));
    check("busy",      64'(busy),      64'(m_inflight || m_ack));
  endtask

  // Inputs are already driven (after a negedge); advance model, clock, and compare.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic clear_inputs();
    req_read = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_data_in = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_read"},  64'(mem_read),  64'd0);
    check({tag, "_mem_write"}, 64'(mem_write), 64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_req_err"},   64'(req_err),   64'd0);
    check({tag, "_req_rdata"}, 64'(req_rdata), 64'd0);
    check({tag, "_grant_id"},  64'(grant_id),  64'd0);
    check({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Random requester bookkeeping.
  bit            pend [N];
  bit            p_rd [N];
  bit            p_wr [N];
  logic [AW-1:0] p_addr [N];
  logic [DW-1:0] p_data [N];

  task automatic arm(input int i);
    int kind;
    kind = $urandom_range(3);
    pend[i]   = 1;
    p_rd[i]   = (kind != 1);
    p_wr[i]   = (kind == 1) || (kind == 3);
    p_addr[i] = $urandom;
    p_data[i] = {$urandom, $urandom};
  endtask

  int cnt, both, gi, last_ready;
  int grants[$];

  initial begin
    clear_inputs();
    rst = 1'b1;
    model_reset();
    #1;
    check_all_zero("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: single read, mem_ready two cycles after the strobe rises
    cnt = 0;
    @(negedge clk); req_read[0] = 1'b1; req_addr[0 +: AW] = 32'h0000_0100; tick(); cnt += int'(mem_read);
    check("t1_addr", 64'(mem_addr), 64'h100);
    @(negedge clk); tick(); cnt += int'(mem_read);
    @(negedge clk); mem_ready = 1'b1; mem_data_in = 64'hAB; tick(); cnt += int'(mem_read);
    check("t1_ready", 64'(req_ready), 64'b001);
    check("t1_rdata", 64'(req_rdata), 64'hAB);
    @(negedge clk); req_read = '0; mem_ready = 1'b0; tick();
    check("t1_read_cycles", 64'(cnt), 64'd2);

    // 3: write from requester 1; req_rdata must keep the previous read value
    @(negedge clk);
    req_write[1] = 1'b1; req_addr[AW +: AW] = 32'h40; req_wdata[DW +: DW] = 64'hDEAD_BEEF;
    tick();
    check("t3_mem_write", 64'(mem_write), 64'd1);
    check("t3_data_out", 64'(mem_data_out), 64'hDEAD_BEEF);
    for (int c = 0; c < 2; c++) begin @(negedge clk); tick(); end
    @(negedge clk); mem_ready = 1'b1; mem_data_in = 64'h1234; tick();
    check("t3_ready", 64'(req_ready), 64'b010);
    check("t3_rdata_kept", 64'(req_rdata), 64'hAB);
    @(negedge clk); clear_inputs(); tick();

    // 2: contention between 0 and 1, four grants
    do_reset();
    grants.delete();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); req_read = 3'b011; mem_ready = 1'b1; mem_data_in = 64'(c); tick();
      if (req_ready != '0) grants.push_back(int'(grant_id));
    end
    check("t2_grant_count", 64'(grants.size()), 64'd4);
    for (int g = 0; g < 4; g++) begin
      gi = (g < grants.size()) ? grants[g] : -1;
      check("t2_grant_order", 64'(gi), 64'(g % 2));
    end
    @(negedge clk); clear_inputs(); tick();

    // 4: timeout with mem_ready stuck low
    do_reset();
    cnt = 0; both = 0;
    @(negedge clk); req_read[0] = 1'b1; req_addr[0 +: AW] = 32'h200;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      if (m_ready != '0) req_read = '0;
      tick();
      cnt += int'(mem_read);
      if (req_ready[0] && req_err[0]) both++;
    end
    check("t4_strobe_cycles", 64'(cnt), 64'd8);
    check("t4_err_with_ready", 64'(both), 64'd1);
    check("t4_rdata_zero", 64'(req_rdata), 64'd0);

    // 5: reset while a read is in flight
    do_reset();
    @(negedge clk); req_read[1] = 1'b1; tick();
    check("t5_inflight", 64'(mem_read), 64'd1);
    @(negedge clk); tick();
    @(negedge clk); rst = 1'b1; model_reset(); #1;
    check_all_zero("t5_async");
    @(negedge clk); rst = 1'b0; req_read = 3'b111; tick();
    check("t5_first_grant", 64'(grant_id), 64'd0);
    @(negedge clk); clear_inputs(); mem_ready = 1'b1; tick();
    @(negedge clk); mem_ready = 1'b0; tick();

    // 6: requester holds its strobe through DONE; next grant only from IDLE
    do_reset();
    cnt = 0; both = 0; last_ready = -10;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk); req_read[1] = 1'b1; mem_ready = 1'b1; tick();
      if (req_ready[1]) begin
        if (last_ready >= 0) check("t6_spacing", 64'(c - last_ready), 64'd3);
        last_ready = c;
        cnt++;
      end
    end
    check("t6_grants", 64'(cnt), 64'd3);
    @(negedge clk); clear_inputs(); tick();

    // random traffic
    do_reset();
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        bit drop;
        if (!pend[i] && $urandom_range(3) == 0) arm(i);
        drop = m_inflight && (m_grant == i) && ($urandom_range(7) == 0);
        req_read[i]  = pend[i] && p_rd[i] && !drop;
        req_write[i] = pend[i] && p_wr[i] && !drop;
        req_addr[i*AW +: AW]  = p_addr[i];
        req_wdata[i*DW +: DW] = p_data[i];
      end
      mem_ready   = ($urandom_range(3) == 0);
      mem_data_in = {$urandom, $urandom};
      tick();
      for (int i = 0; i < N; i++) begin
        if (m_ready[i]) begin
          pend[i] = 0;
          if ($urandom_range(2) == 0) arm(i);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
